// File: rtl/itoer_if.sv
// mb8_io: byte-wide memory bus used by the interpreter datapath blocks.
//   we  - write strobe, one byte per cycle
//   ai  - byte address [ASZ]
//   vi  - write data [DSZ]
// master drives all three signals; slave observes them.
interface mb8_io #(
    parameter int unsigned ASZ = 17,
    parameter int unsigned DSZ = 8
);
    logic           we;
    logic [ASZ-1:0] ai;
    logic [DSZ-1:0] vi;

    modport master (output we, output ai, output vi);
    modport slave  (input  we, input  ai, input  vi);
endinterface

// File: rtl/itoer.sv
// itoer: renders a 32-bit cell as ASCII decimal or hex digits into byte memory,
// least significant digit first, ending just below a caller-supplied pad address
// (Forth <# # #> style).
//
// Ports:
//   clk, rst  - clock; synchronous active-high reset
//   mb_if     - mb8_io master: we/ai/vi byte writes (never reads)
//   en        - start/hold level; rising in IDLE starts, low aborts
//   hex       - 1: base 16, 0: base 10 (sampled at start)
//   vi        - value to convert (sampled at start)
//   pad       - address one past the last character (sampled at start)
//   bsy       - conversion in progress
//   done      - one-cycle pulse when the string is complete
//   ao, len   - first-character address and character count of the last
//               completed conversion
//
// Optional feature macro: ITOER_SIGN_EN
//   When defined, decimal conversions treat vi as two's complement and emit a
//   leading '-' for negative values. Hex is always unsigned.
module itoer #(
    parameter int unsigned DSZ = 8,
    parameter int unsigned ASZ = 17
) (
    input  logic           clk,
    input  logic           rst,
    mb8_io.master          mb_if,
    input  logic           en,
    input  logic           hex,
    input  logic [31:0]    vi,
    input  logic [ASZ-1:0] pad,
    output logic           bsy,
    output logic           done,
    output logic [ASZ-1:0] ao,
    output logic [3:0]     len
);

    typedef enum logic [2:0] {
        StIdle,
        StDiv,
        StPut,
`ifdef ITOER_SIGN_EN
        StSgn,
`endif
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [31:0]    num_q, num_d;     // dividend, becomes quotient
    logic [3:0]     rem_q, rem_d;     // partial remainder, becomes digit
    logic [4:0]     cnt_q, cnt_d;     // decimal divide step counter
    logic           hex_q, hex_d;
    logic [ASZ-1:0] ptr_q, ptr_d;
    logic [3:0]     wlen_q, wlen_d;   // working character count
    logic [ASZ-1:0] ao_q, ao_d;
    logic [3:0]     len_q, len_d;
    logic           done_q, done_d;
`ifdef ITOER_SIGN_EN
    logic           neg_q, neg_d;
`endif

    logic           bus_we;
    logic [ASZ-1:0] bus_ai;
    logic [7:0]     bus_vi;

    // One restoring step of unsigned divide by 10.
    logic [4:0] part;
    logic [4:0] part_sub;
    logic       part_ge;

    assign part     = {rem_q, num_q[31]};
    assign part_sub = part - 5'd10;
    assign part_ge  = (part >= 5'd10);

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        ptr_d   = ptr_q;
        wlen_d  = wlen_q;
        ao_d    = ao_q;
        len_d   = len_q;
        done_d  = 1'b0;
`ifdef ITOER_SIGN_EN
        neg_d   = neg_q;
`endif
        bus_we  = 1'b0;
        bus_ai  = '0;
        bus_vi  = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    num_d   = vi;
                    hex_d   = hex;
                    ptr_d   = pad;
                    wlen_d  = 4'd0;
                    rem_d   = 4'd0;
                    cnt_d   = 5'd0;
                    state_d = StDiv;
`ifdef ITOER_SIGN_EN
                    neg_d = ~hex & vi[31];
                    if (~hex & vi[31]) begin
                        // 0x80000000 negates to itself, which is the right magnitude unsigned
                        num_d = 32'd0 - vi;
                    end
`endif
                end
            end
            StDiv: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (hex_q) begin
                    rem_d   = num_q[3:0];
                    num_d   = {4'd0, num_q[31:4]};
                    state_d = StPut;
                end else begin
                    rem_d = part_ge ? part_sub[3:0] : part[3:0];
                    num_d = {num_q[30:0], part_ge};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StPut;
                    end
                end
            end
            StPut: begin
                bus_we = 1'b1;
                bus_ai = ptr_q - ASZ'(1);
                bus_vi = (rem_q < 4'd10) ? (8'h30 + {4'd0, rem_q}) : (8'h37 + {4'd0, rem_q});
                ptr_d  = ptr_q - ASZ'(1);
                wlen_d = wlen_q + 4'd1;
                rem_d  = 4'd0;
                cnt_d  = 5'd0;
                if (!en) begin
                    state_d = StIdle;
                end else if (num_q == 32'd0) begin
`ifdef ITOER_SIGN_EN
                    state_d = neg_q ? StSgn : StDone;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StDiv;
                end
            end
`ifdef ITOER_SIGN_EN
            StSgn: begin
                bus_we  = 1'b1;
                bus_ai  = ptr_q - ASZ'(1);
                bus_vi  = 8'h2D;
                ptr_d   = ptr_q - ASZ'(1);
                wlen_d  = wlen_q + 4'd1;
                state_d = en ? StDone : StIdle;
            end
`endif
            StDone: begin
                if (!en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Results are published only on a completed conversion, so an abort
        // leaves the previous ao/len visible.
        if (state_d == StDone && state_q != StDone) begin
            done_d = 1'b1;
            ao_d   = ptr_d;
            len_d  = wlen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            num_q   <= 32'd0;
            rem_q   <= 4'd0;
            cnt_q   <= 5'd0;
            hex_q   <= 1'b0;
            ptr_q   <= '0;
            wlen_q  <= 4'd0;
            ao_q    <= '0;
            len_q   <= 4'd0;
            done_q  <= 1'b0;
`ifdef ITOER_SIGN_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            ptr_q   <= ptr_d;
            wlen_q  <= wlen_d;
            ao_q    <= ao_d;
            len_q   <= len_d;
            done_q  <= done_d;
`ifdef ITOER_SIGN_EN
            neg_q   <= neg_d;
`endif
        end
    end

`ifdef ITOER_SIGN_EN
    assign bsy = (state_q == StDiv) || (state_q == StPut) || (state_q == StSgn);
`else
    assign bsy = (state_q == StDiv) || (state_q == StPut);
`endif
    assign done = done_q;
    assign ao   = ao_q;
    assign len  = len_q;

    assign mb_if.we = bus_we;
    assign mb_if.ai = bus_ai;
    assign mb_if.vi = DSZ'(bus_vi);

endmodule

// File: tb/tb_itoer.sv
module tb_itoer;
    localparam int unsigned ASZ = 17;
    localparam int unsigned DSZ = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           hex;
    logic [31:0]    vi;
    logic [ASZ-1:0] pad;
    logic           bsy;
    logic           done;
    logic [ASZ-1:0] ao;
    logic [3:0]     len;

    mb8_io #(.ASZ(ASZ), .DSZ(DSZ)) mb_if ();

    itoer #(.DSZ(DSZ), .ASZ(ASZ)) dut (
        .clk   (clk),
        .rst   (rst),
        .mb_if (mb_if),
        .en    (en),
        .hex   (hex),
        .vi    (vi),
        .pad   (pad),
        .bsy   (bsy),
        .done  (done),
        .ao    (ao),
        .len   (len)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Bus / status monitor, sampled on the falling edge.
    logic [ASZ-1:0] wr_a[$];
    logic [7:0]     wr_d[$];
    int bsy_cnt   = 0;
    int done_cnt  = 0;
    int quiet_bad = 0;

    always @(negedge clk) begin
        if (mb_if.we === 1'b1) begin
            wr_a.push_back(mb_if.ai);
            wr_d.push_back(mb_if.vi);
        end else if (mb_if.ai !== '0 || mb_if.vi !== '0) begin
            quiet_bad++;
        end
        if (bsy === 1'b1) bsy_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    // Reference string, least significant character first (write order).
    logic [7:0]     exp_q[$];
    logic [ASZ-1:0] last_ao  = '0;
    logic [3:0]     last_len = 4'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        wr_a.delete();
        wr_d.delete();
        bsy_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic model(input logic [31:0] v, input bit h, output int ndig, output bit neg);
        logic [31:0] m;
        int unsigned d;
        exp_q.delete();
        m   = v;
        neg = 1'b0;
`ifdef ITOER_SIGN_EN
        if (!h && v[31]) begin
            neg = 1'b1;
            m   = -v;
        end
`endif
        do begin
            d = h ? (m % 16) : (m % 10);
            m = h ? (m / 16) : (m / 10);
            exp_q.push_back(d < 10 ? 8'(8'h30 + d) : 8'(8'h41 + d - 10));
        end while (m != 0);
        ndig = exp_q.size();
        if (neg) exp_q.push_back(8'h2D);
    endtask

    task automatic run_conv(input string tag, input logic [31:0] v, input bit h,
                            input logic [ASZ-1:0] p);
        int             nd;
        bit             ng;
        int             k;
        int             exp_bsy;
        int             bad;
        int             n;
        logic [ASZ-1:0] a;
        model(v, h, nd, ng);
        exp_bsy = h ? 2 * nd : 33 * nd + (ng ? 1 : 0);
        clear_mon();
        vi  = v;
        hex = h;
        pad = p;
        en  = 1'b1;
        step();
        // Inputs are latched at start; scramble them mid-conversion.
        vi  = $urandom;
        hex = 1'($urandom_range(0, 1));
        pad = ASZ'($urandom);
        k = 1;
        while (done !== 1'b1 && k < 600) begin
            step();
            k++;
        end
        check({tag, " done_latency"}, 64'(k), 64'(exp_bsy + 1));
        // Hold en high: no restart, no further writes or pulses.
        repeat (4) step();
        check({tag, " bsy_cycles"}, 64'(bsy_cnt), 64'(exp_bsy));
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " bsy_after"}, 64'(bsy), 64'd0);
        n = exp_q.size();
        a = p - ASZ'(n);
        check({tag, " ao"}, 64'(ao), 64'(a));
        check({tag, " len"}, 64'(len), 64'(n));
        check({tag, " wr_count"}, 64'(wr_d.size()), 64'(n));
        bad = 0;
        for (int i = 0; i < n && i < wr_d.size(); i++) begin
            a = p - ASZ'(i + 1);
            if (wr_d[i] !== exp_q[i] || wr_a[i] !== a) bad++;
        end
        check({tag, " wr_bytes_bad"}, 64'(bad), 64'd0);
        last_ao  = p - ASZ'(n);
        last_len = 4'(n);
        en = 1'b0;
        step();
    endtask

    // Start 1234 decimal, kill it during the second digit's divide.
    task automatic abort_conv(input string tag, input bit use_rst);
        clear_mon();
        vi  = 32'd1234;
        hex = 1'b0;
        pad = 17'h300;
        en  = 1'b1;
        repeat (40) step();
        if (use_rst) rst = 1'b1;
        en = 1'b0;
        step();
        rst = 1'b0;
        check({tag, " bsy_next"}, 64'(bsy), 64'd0);
        repeat (200) step();
        check({tag, " wr_count"}, 64'(wr_d.size()), 64'd1);
        if (wr_d.size() > 0) check({tag, " first_byte"}, 64'(wr_d[0]), 64'h34);
        check({tag, " no_done"}, 64'(done_cnt), 64'd0);
        if (use_rst) begin
            last_ao  = '0;
            last_len = 4'd0;
        end
        check({tag, " ao_kept"}, 64'(ao), 64'(last_ao));
        check({tag, " len_kept"}, 64'(len), 64'(last_len));
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        hex = 1'b0;
        vi  = 32'd0;
        pad = '0;
        step();
        step();
        rst = 1'b0;
        check("reset bsy", 64'(bsy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset ao", 64'(ao), 64'd0);
        check("reset len", 64'(len), 64'd0);
        check("reset we", 64'(mb_if.we), 64'd0);
        step();

        run_conv("zero", 32'd0, 1'b0, 17'h100);
        run_conv("dec1234", 32'd1234, 1'b0, 17'h100);
        run_conv("hexbeef", 32'hDEADBEEF, 1'b1, 17'h200);
        run_conv("hexwrap", 32'hDEADBEEF, 1'b1, 17'h0);
        run_conv("decmax", 32'hFFFFFFFF, 1'b0, 17'h400);
        run_conv("decmin", 32'h80000000, 1'b0, 17'h500);
        run_conv("hexzero", 32'd0, 1'b1, 17'h1);

        abort_conv("abort_en", 1'b0);
        run_conv("after_en", 32'd42, 1'b0, 17'h300);
        abort_conv("abort_rst", 1'b1);
        run_conv("after_rst", 32'd42, 1'b0, 17'h300);

        for (int r = 0; r < 10; r++) begin
            run_conv($sformatf("rand%0d", r), $urandom, 1'($urandom_range(0, 1)),
                     ASZ'($urandom));
        end

        check("bus_quiet", 64'(quiet_bad), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/itoer.md
Name: itoer

Overview:
- Number-to-string converter; the write-direction counterpart of the atoi parser.
- Takes a 32-bit cell value and renders it as ASCII digits (decimal or hex) into byte memory through an mb8_io master port.
- Digits are written backwards, ending just below a caller-supplied pad address, in the same way as Forth <# # #>.
- Used by the number-output words ('.', 'U.', '.S') and muxed onto the shared memory bus by the interpreter glue.

Parameters:
DSZ, 8, memory data width (bits)
ASZ, 17, memory address width (128K)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
mb_if  mb8_io.master  -  memory bus: we, ai[ASZ], vi[DSZ]
en  input  1  start/hold level; rising into IDLE starts a conversion, low aborts
hex  input  1  1: base 16, 0: base 10; sampled at start
vi  input  32  value to convert; sampled at start
pad  input  ASZ  address one past the last output character; sampled at start
bsy  output  1  conversion in progress
done  output  1  one-cycle pulse when the string is complete
ao  output  ASZ  address of the first character (valid from done until next start)
len  output  4  character count, 1..11 (valid from done until next start)

Behaviour:
- Reset (rst=1 at posedge): state IDLE, bsy=0, done=0, ao=0, len=0, mb_if.we=0.
- rst has priority over all other inputs.
- States: IDLE, DIV, PUT, SGN (only with the optional feature), DONE.
- IDLE:
  - When en=1: latch num=vi, hex, ptr=pad; clear len; go to DIV.
  - bsy rises on the next cycle.
- DIV, hex mode:
  - 1 cycle: digit=num[3:0], num>>=4.
- DIV, decimal mode:
  - 32-cycle restoring shift-subtract divide by 10, unsigned.
  - quotient replaces num; remainder becomes digit.
- PUT (1 cycle):
  - Drive mb_if.we=1, ai=ptr-1, vi=ASCII(digit).
  - Register updates: ptr<=ptr-1, len<=len+1.
  - If quotient==0: go to SGN/DONE. Otherwise go to DIV.
- ASCII mapping: 0-9 → 0x30+d; 10-15 → 0x41+(d-10), i.e. uppercase 'A'-'F'.
- Do-while semantics: value 0 produces exactly one '0'.
- No leading zeros.
- DONE:
  - done=1 for exactly one cycle on entry; bsy=0.
  - ao=ptr, len final.
  - Stays in DONE until en=0, then goes to IDLE. A new start requires en to be low for at least one cycle.
- Latency, with start at cycle T0 and N = digit count:
  - hex: bsy high for 2N cycles, done at T0+2N+1.
  - decimal: bsy high for 33N cycles, done at T0+33N+1.
- Bus:
  - mb_if.we=1 only in PUT.
  - ai/vi are don't-care when we=0; they are driven to 0 so the bus stays quiet.
  - The block never reads memory.
- Address arithmetic is modulo 2^ASZ: pad=0 writes at 2^ASZ-1 downward.
- Abort cases:
  - en=0 in DIV/PUT/SGN: IDLE at the next edge, bsy=0, no done pulse, len/ao unchanged from the last completed conversion.
  - Bytes already written stay in memory.
  - Reset mid-operation behaves the same, but ao/len are cleared.
- Inputs vi/hex/pad changing during a conversion have no effect.

Optional Feature:
ITOER_SIGN_EN
- Defined, decimal mode:
  - vi is two's complement. If vi[31]=1, num=-vi; the 0x80000000 magnitude fits unsigned.
  - After the last digit, SGN writes '-' (0x2D) at ptr-1, ptr<=ptr-1, len+1 (1 extra cycle).
- Defined, hex mode: always unsigned.
- Not defined: all values are unsigned, the SGN state is absent, and max len=10.

Test Plan:
- vi=0, hex=0, pad=0x100 → single write 0x30@0x0FF; bsy 33 cycles; done; ao=0x0FF, len=1.
- vi=1234, hex=0, pad=0x100 → writes '4'@0xFF, '3'@0xFE, '2'@0xFD, '1'@0xFC in that order; ao=0xFC, len=4; bsy 132 cycles.
- vi=0xDEADBEEF, hex=1, pad=0x200 → "DEADBEEF" at 0x1F8..0x1FF; len=8; bsy 16 cycles; pad=0 variant wraps to 0x1FFF8..0x1FFFF.
- vi=0xFFFFFFFF, hex=0 → without ITOER_SIGN_EN: "4294967295", len=10.
- Same vi=0xFFFFFFFF, hex=0 → with ITOER_SIGN_EN: "-1", len=2. Also vi=0x80000000 → "-2147483648", len=11.
- rst (or en=0) during the second decimal digit's DIV → next cycle bsy=0, no done, no further writes. Then en 0→1 with vi=42 → "42", done pulse once.
- Back-to-back: hold en=1 after done → no restart, no writes. Drop en 1 cycle then raise → second conversion starts; done fires exactly once per conversion.
